// File: rtl/counter_modn_cascade.sv
// Multi-digit modulo-N up/down counter with parallel load, cascade terminal count and wrap pulse.
// Optional macro COUNTER_MATCH_EN adds a registered compare-match output.
module counter_modn_cascade #(
  parameter int N      = 10,
  parameter int DIGITS = 4,
  localparam int W     = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [DIGITS*W-1:0] d,
`ifdef COUNTER_MATCH_EN
  input  logic [DIGITS*W-1:0] match_val,
  output logic                match,
`endif
  output logic [DIGITS*W-1:0] q,
  output logic                rco,
  output logic                tc
);

  localparam logic [W-1:0] MAXV = W'(N - 1);

  logic [DIGITS*W-1:0] cnt_q, cnt_d;
  logic                rco_q, rco_d;
  logic                all_term;

  // Ripple the "all lower digits terminal" carry through the digits in one pass.
  always_comb begin
    logic         carry;
    logic         term;
    logic [W-1:0] dig;
    logic [W-1:0] ld;
    cnt_d = cnt_q;
    rco_d = 1'b0;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig  = cnt_q[i*W +: W];
      ld   = d[i*W +: W];
      term = up ? (dig == MAXV) : (dig == '0);
      if (load) begin
        cnt_d[i*W +: W] = (ld > MAXV) ? MAXV : ld;
      end else if (en && carry) begin
        if (up) cnt_d[i*W +: W] = term ? '0 : dig + W'(1);
        else    cnt_d[i*W +: W] = term ? MAXV : dig - W'(1);
      end
      carry = carry & term;
    end
    all_term = carry;
    if (!load && en) rco_d = all_term;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rco_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rco_q <= rco_d;
    end
  end

  assign q   = cnt_q;
  assign rco = rco_q;
  assign tc  = en & all_term;

`ifdef COUNTER_MATCH_EN
  logic match_q, match_d;

  // Only a counting step can raise match; a load landing on match_val does not.
  always_comb begin
    match_d = !load && en && (cnt_d == match_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end

  assign match = match_q;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        assert (cnt_q[i*W +: W] <= MAXV);
      end
    end
  end
`endif

endmodule

// File: tb/tb_counter_modn_cascade.sv
// Scoreboard bench: two instances (N=10 x2 digits, N=6 x3 digits) checked against an integer mod-N^DIGITS model.
module tb_counter_modn_cascade;

  localparam int MA = 100;  // 10^2
  localparam int MB = 216;  // 6^3
  localparam int MATCH_A = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] dA = '0, qA;
  logic [8:0] dB = '0, qB;
  logic       rcoA, tcA, rcoB, tcB;
`ifdef COUNTER_MATCH_EN
  logic [7:0] mvA = 8'h07;
  logic [8:0] mvB = '0;
  logic       matchA, matchB;
`endif

  always #5 clk = ~clk;

  counter_modn_cascade #(.N(10), .DIGITS(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(dA),
`ifdef COUNTER_MATCH_EN
    .match_val(mvA), .match(matchA),
`endif
    .q(qA), .rco(rcoA), .tc(tcA)
  );

  counter_modn_cascade #(.N(6), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(dB),
`ifdef COUNTER_MATCH_EN
    .match_val(mvB), .match(matchB),
`endif
    .q(qB), .rco(rcoB), .tc(tcB)
  );

  typedef struct {
    int qA, rA, tA, mA, qB, rB, tB;
  } item_t;
  item_t sb[$];

  int compared = 0, mismatched = 0;
  int vA = 0, rA = 0, mA = 0, vB = 0, rB = 0;

  function automatic int packv(int v, int n, int dg, int w);
    int r = 0;
    for (int i = 0; i < dg; i++) begin
      r = r | ((v % n) << (i * w));
      v = v / n;
    end
    return r;
  endfunction

  function automatic int load_val(int bits, int n, int dg, int w);
    int val = 0, mul = 1, dig;
    for (int i = 0; i < dg; i++) begin
      dig = (bits >> (i * w)) & ((1 << w) - 1);
      if (dig > n - 1) dig = n - 1;
      val = val + dig * mul;
      mul = mul * n;
    end
    return val;
  endfunction

  task automatic adv(input int m, input int v, input bit e, input bit u, input bit l,
                     input int ld, output int nv, output int nr);
    nv = v;
    nr = 0;
    if (l) nv = ld;
    else if (e) begin
      if (u) begin nr = (v == m - 1) ? 1 : 0; nv = (v + 1) % m; end
      else   begin nr = (v == 0) ? 1 : 0;     nv = (v + m - 1) % m; end
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input logic [7:0] da, input logic [8:0] db);
    item_t it;
    int nvA, nrA, nvB, nrB;
    @(posedge clk);
    #1;
    rst = r; en = e; up = u; load = l; dA = da; dB = db;
    if (r) begin vA = 0; rA = 0; mA = 0; vB = 0; rB = 0; end
    it.qA = packv(vA, 10, 2, 4);
    it.rA = rA;
    it.mA = mA;
    it.tA = (e && (u ? (vA == MA - 1) : (vA == 0))) ? 1 : 0;
    it.qB = packv(vB, 6, 3, 3);
    it.rB = rB;
    it.tB = (e && (u ? (vB == MB - 1) : (vB == 0))) ? 1 : 0;
    sb.push_back(it);
    if (!r) begin
      adv(MA, vA, e, u, l, load_val(int'(da), 10, 2, 4), nvA, nrA);
      adv(MB, vB, e, u, l, load_val(int'(db), 6, 3, 3), nvB, nrB);
      mA = (!l && e && nvA == MATCH_A) ? 1 : 0;
      vA = nvA; rA = nrA; vB = nvB; rB = nrB;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check("qA", int'(qA), it.qA);
        check("rcoA", int'(rcoA), it.rA);
        check("tcA", int'(tcA), it.tA);
        check("qB", int'(qB), it.qB);
        check("rcoB", int'(rcoB), it.rB);
        check("tcB", int'(tcB), it.tB);
`ifdef COUNTER_MATCH_EN
        check("matchA", int'(matchA), it.mA);
`endif
      end
    end
  end

  initial begin : stimulus
    drive(1, 0, 1, 0, 8'h00, 9'o000);
    drive(1, 0, 1, 0, 8'h00, 9'o000);
    drive(0, 0, 1, 1, 8'h47, 9'o123);          // load 47 / 123
    drive(0, 0, 1, 0, 8'h00, 9'o000);          // hold so 47 is observed
    drive(1, 1, 1, 0, 8'h00, 9'o000);          // async reset mid-cycle
    drive(0, 0, 1, 1, 8'h98, 9'o000);          // load 98
    drive(0, 1, 1, 0, 8'h00, 9'o000);          // 98
    drive(0, 1, 1, 0, 8'h00, 9'o000);          // 99, tc=1
    drive(0, 1, 1, 0, 8'h00, 9'o000);          // 00, rco=1
    drive(0, 0, 1, 0, 8'h00, 9'o000);          // 01, rco=0
    drive(0, 1, 1, 1, 8'hC3, 9'o777);          // clamp -> 93 / 555, no step
    drive(0, 0, 1, 1, 8'h42, 9'o000);          // load 42 / 000
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 8'h00, 9'o000);
    drive(0, 1, 1, 0, 8'h00, 9'o000);          // -> 43
    drive(0, 1, 0, 0, 8'h00, 9'o000);          // -> 42
    drive(0, 1, 1, 0, 8'h00, 9'o000);          // -> 43
    drive(0, 0, 0, 1, 8'h50, 9'o000);          // B back to 000
    drive(0, 1, 0, 0, 8'h00, 9'o000);          // B tc=1, wraps to 555
    drive(0, 0, 0, 0, 8'h00, 9'o000);          // B 555 rco=1
    drive(0, 0, 1, 1, 8'h05, 9'o000);          // match sequence
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 8'h00, 9'o000);
    drive(0, 0, 1, 1, 8'h07, 9'o000);          // load 07: no match
    drive(0, 0, 1, 0, 8'h00, 9'o000);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
            8'($urandom), 9'($urandom));
    end
    drive(0, 0, 1, 0, 8'h00, 9'o000);
    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d items left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
